// File: rtl/gen1_2_tx_scheduler.sv
// -----------------------------------------------------------------------------
// gen1_2_tx_scheduler
//
// Transmit-side packet scheduler for a Gen1/Gen2 lane datapath. It merges two
// request streams, TLPs (byte-serial, variable length) and DLLPs (6 bytes,
// presented in parallel), into one symbol stream. Each packet is wrapped with
// K-symbol framing:
//   TLP : STP (FB) , payload bytes ... , END (FD) or EDB (FE) when nullified
//   DLLP: SDP (5C) , bytes 0..5 , END (FD)
//
// Arbitration takes place in IDLE and on the transfer cycle of the closing
// END/EDB symbol, so packets can follow each other with no idle bubble. DLLPs
// win over a waiting TLP, but at most DLLP_BURST times in a row. A TLP that has
// started is never interrupted.
//
// Parameters
//   DLLP_BURST   maximum consecutive DLLP grants while a TLP is waiting
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   tlp_valid    TLP byte available on tlp_data
//   tlp_data     TLP byte stream, header first
//   tlp_last     current tlp_data byte is the final one of the TLP
//   tlp_nullify  sampled with the last byte; closes the TLP with EDB
//   tlp_ready    TLP byte consumed this cycle
//   dllp_valid   DLLP pending on dllp_data
//   dllp_data    6-byte DLLP, byte 0 in [47:40], byte 5 in [7:0]
//   dllp_ready   one-cycle pulse, dllp_data captured this cycle
//   sym_data     symbol to the lane datapath
//   sym_dk       1 = K-symbol, 0 = D-symbol
//   sym_valid    a symbol is presented this cycle
//   sym_ready    datapath accepts the symbol (transfer = sym_valid & sym_ready)
//   busy         high in every state except IDLE
// -----------------------------------------------------------------------------
module gen1_2_tx_scheduler #(
  parameter int DLLP_BURST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tlp_valid,
  input  logic [7:0]  tlp_data,
  input  logic        tlp_last,
  input  logic        tlp_nullify,
  output logic        tlp_ready,
  input  logic        dllp_valid,
  input  logic [47:0] dllp_data,
  output logic        dllp_ready,
  output logic [7:0]  sym_data,
  output logic        sym_dk,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        busy
);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  // Wide enough to hold 0..DLLP_BURST; never narrower than one bit.
  localparam int STREAK_W = (DLLP_BURST < 1) ? 1 : $clog2(DLLP_BURST + 1);

  typedef enum logic [2:0] {
    IDLE,
    TLP_STP,
    TLP_BODY,
    TLP_END,
    DLLP_SDP,
    DLLP_BODY,
    DLLP_END
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [2:0]          byte_cnt;
  logic                nullify_q;
  logic [47:0]         dllp_q;

  logic arb_en;
  logic streak_ok;
  logic grant_dllp;
  logic grant_tlp;

  // Byte idx of a latched DLLP, byte 0 being the most significant.
  function automatic logic [7:0] dllp_byte(input logic [47:0] d,
                                           input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = d[47:40];
      3'd1:    b = d[39:32];
      3'd2:    b = d[31:24];
      3'd3:    b = d[23:16];
      3'd4:    b = d[15:8];
      3'd5:    b = d[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Closing symbol of a TLP.
  function automatic logic [7:0] tlp_close(input logic nullified);
    return nullified ? K_EDB : K_END;
  endfunction

  // Arbitration point: IDLE, or the closing symbol of the current packet being
  // accepted. Gating with sym_ready keeps everything frozen under backpressure
  // (IDLE included); gating with rst_n keeps dllp_ready low while in reset.
  assign arb_en = rst_n & sym_ready &
                  ((state == IDLE) | (state == TLP_END) | (state == DLLP_END));

  assign streak_ok  = int'(streak) < DLLP_BURST;
  assign grant_dllp = arb_en & dllp_valid & (~tlp_valid | streak_ok);
  assign grant_tlp  = arb_en & ~grant_dllp & tlp_valid;

  assign dllp_ready = grant_dllp;
  assign busy       = (state != IDLE);

  // Symbol presentation: decoded from the registered state, except the TLP
  // payload which flows straight through from the source.
  always_comb begin
    sym_valid = 1'b0;
    sym_data  = 8'h00;
    sym_dk    = 1'b0;
    tlp_ready = 1'b0;
    case (state)
      TLP_STP: begin
        sym_valid = 1'b1;
        sym_data  = K_STP;
        sym_dk    = 1'b1;
      end
      TLP_BODY: begin
        // A source gap shows up as sym_valid=0; nothing is inserted.
        sym_valid = tlp_valid;
        sym_data  = tlp_data;
        tlp_ready = rst_n & tlp_valid & sym_ready;
      end
      TLP_END: begin
        sym_valid = 1'b1;
        sym_data  = tlp_close(nullify_q);
        sym_dk    = 1'b1;
      end
      DLLP_SDP: begin
        sym_valid = 1'b1;
        sym_data  = K_SDP;
        sym_dk    = 1'b1;
      end
      DLLP_BODY: begin
        sym_valid = 1'b1;
        sym_data  = dllp_byte(dllp_q, byte_cnt);
      end
      DLLP_END: begin
        sym_valid = 1'b1;
        sym_data  = K_END;
        sym_dk    = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state. A reset abandons any packet in flight; no closing symbol is
  // sent and output resumes only on a fresh grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      byte_cnt  <= '0;
      nullify_q <= 1'b0;
    end else if (grant_dllp) begin
      state    <= DLLP_SDP;
      byte_cnt <= '0;
      // Only DLLPs that jump ahead of a waiting TLP count toward the burst.
      streak   <= tlp_valid ? streak + 1'b1 : '0;
    end else if (grant_tlp) begin
      state  <= TLP_STP;
      streak <= '0;
    end else if (arb_en) begin
      state <= IDLE;
    end else if (sym_ready) begin
      case (state)
        TLP_STP:  state <= TLP_BODY;
        TLP_BODY: begin
          if (tlp_valid && tlp_last) begin
            nullify_q <= tlp_nullify;
            state     <= TLP_END;
          end
        end
        DLLP_SDP: state <= DLLP_BODY;
        DLLP_BODY: begin
          if (byte_cnt == 3'd5) begin
            state <= DLLP_END;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // DLLP payload holding register; data only, captured on the grant.
  always_ff @(posedge clk) begin
    if (grant_dllp) begin
      dllp_q <= dllp_data;
    end
  end

endmodule

// File: tb/tb_gen1_2_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gen1_2_tx_scheduler
//
// Bench for gen1_2_tx_scheduler. Sources are queues of TLP bytes and DLLPs;
// a packet-level reference (expected symbol list per granted packet, plus the
// DLLP burst counter) predicts every output on every cycle. Directed scenarios
// pin the reference with literal symbol sequences, then a randomized run with
// source gaps and random backpressure exercises everything together.
// -----------------------------------------------------------------------------
module tb_gen1_2_tx_scheduler;

  localparam int BURST = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tlp_valid;
  logic [7:0]  tlp_data;
  logic        tlp_last;
  logic        tlp_nullify;
  logic        tlp_ready;
  logic        dllp_valid;
  logic [47:0] dllp_data;
  logic        dllp_ready;
  logic [7:0]  sym_data;
  logic        sym_dk;
  logic        sym_valid;
  logic        sym_ready;
  logic        busy;

  gen1_2_tx_scheduler #(.DLLP_BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tlp_valid  (tlp_valid),
    .tlp_data   (tlp_data),
    .tlp_last   (tlp_last),
    .tlp_nullify(tlp_nullify),
    .tlp_ready  (tlp_ready),
    .dllp_valid (dllp_valid),
    .dllp_data  (dllp_data),
    .dllp_ready (dllp_ready),
    .sym_data   (sym_data),
    .sym_dk     (sym_dk),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       nul;
  } tbyte_t;

  tbyte_t      tlp_q[$];
  logic [47:0] dllp_src[$];
  logic [8:0]  log_sym[$];   // {dk, data} of every transferred symbol
  int          log_cyc[$];
  logic [8:0]  exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dr_cnt = 0;
  int dr_cyc = -1;
  bit mon_en   = 1'b0;
  bit gap_en   = 1'b0;
  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive_inputs();
    if (tlp_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      tlp_valid   = 1'b1;
      tlp_data    = tlp_q[0].d;
      tlp_last    = tlp_q[0].last;
      tlp_nullify = tlp_q[0].nul;
    end else begin
      tlp_valid   = 1'b0;
      tlp_data    = 8'($urandom);
      tlp_last    = 1'($urandom);
      tlp_nullify = 1'($urandom);
    end
    if (dllp_src.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      dllp_valid = 1'b1;
      dllp_data  = dllp_src[0];
    end else begin
      dllp_valid = 1'b0;
      dllp_data  = {16'($urandom), 32'($urandom)};
    end
    sym_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  endtask

  // One clock: consume whatever the DUT accepted, then drive the next inputs.
  task automatic step();
    bit tf;
    bit df;
    @(negedge clk);
    tf = tlp_valid && tlp_ready;
    df = dllp_valid && dllp_ready;
    @(posedge clk);
    #1;
    if (tf) tlp_q.delete(0);
    if (df) dllp_src.delete(0);
    drive_inputs();
  endtask

  task automatic push_tlp(input logic [7:0] base, input int n, input bit nul, input bit rnd);
    tbyte_t b;
    for (int i = 0; i < n; i++) begin
      b.d    = rnd ? 8'($urandom) : base + 8'(i);
      b.last = (i == n - 1);
      b.nul  = (i == n - 1) && nul;
      tlp_q.push_back(b);
    end
  endtask

  task automatic exp_dllp(input logic [47:0] d);
    exp_q.push_back({1'b1, 8'h5C});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, d[47-8*i -: 8]});
    exp_q.push_back({1'b1, 8'hFD});
  endtask

  task automatic exp_tlp(input logic [7:0] base, input int n, input bit nul);
    exp_q.push_back({1'b1, 8'hFB});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, base + 8'(i)});
    exp_q.push_back({1'b1, nul ? 8'hFE : 8'hFD});
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (log_sym.size() < n && k < 200) begin
      step();
      k++;
    end
    chk({name, "_timeout"}, 64'(log_sym.size() >= n), 64'd1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, 64'(log_sym.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_sym%0d", name, i),
          (i < log_sym.size()) ? 64'(log_sym[i]) : 64'h3FF, 64'(exp_q[i]));
    end
  endtask

  task automatic clear_log();
    log_sym.delete();
    log_cyc.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Reference: the packet in flight is a list of symbols still to send; a TLP
  // payload is a pass-through phase between its STP and its closing symbol.
  // ---------------------------------------------------------------------------
  bit         m_busy = 1'b0;
  bit         m_body = 1'b0;
  bit         m_pre  = 1'b0;
  int         m_streak = 0;
  logic [8:0] m_syms[$];

  always @(negedge clk) begin : monitor
    logic       e_sv, e_k, e_tr, e_dr, e_busy;
    logic [7:0] e_d;
    bit         arb, gd, gt;
    cyc++;
    if (dllp_ready === 1'b1) begin
      dr_cnt++;
      dr_cyc = cyc;
    end
    if (sym_valid === 1'b1 && sym_ready === 1'b1) begin
      log_sym.push_back({sym_dk, sym_data});
      log_cyc.push_back(cyc);
    end
    if (mon_en) begin
      e_sv = 1'b0; e_k = 1'b0; e_d = 8'h00; e_tr = 1'b0;
      e_busy = m_busy;
      if (m_busy && m_body) begin
        e_sv = tlp_valid;
        e_d  = tlp_data;
        e_tr = rst_n && tlp_valid && sym_ready;
      end else if (m_busy) begin
        e_sv = 1'b1;
        {e_k, e_d} = m_syms[0];
      end
      arb  = rst_n && sym_ready &&
             (!m_busy || (!m_body && !m_pre && m_syms.size() == 1));
      gd   = arb && dllp_valid && (!tlp_valid || m_streak < BURST);
      gt   = arb && !gd && tlp_valid;
      e_dr = gd;
      chk("model", {sym_valid, sym_dk, sym_data, tlp_ready, dllp_ready, busy},
                   {e_sv, e_k, e_d, e_tr, e_dr, e_busy});
      if (!rst_n) begin
        m_busy = 1'b0; m_body = 1'b0; m_pre = 1'b0; m_streak = 0;
        m_syms.delete();
      end else if (arb) begin
        m_syms.delete();
        m_body = 1'b0;
        m_pre  = 1'b0;
        if (gd) begin
          m_streak = tlp_valid ? m_streak + 1 : 0;
          m_syms.push_back({1'b1, 8'h5C});
          for (int i = 0; i < 6; i++) m_syms.push_back({1'b0, dllp_data[47-8*i -: 8]});
          m_syms.push_back({1'b1, 8'hFD});
          m_busy = 1'b1;
        end else if (gt) begin
          m_streak = 0;
          m_syms.push_back({1'b1, 8'hFB});
          m_pre  = 1'b1;
          m_busy = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_busy && sym_ready) begin
        if (m_body) begin
          if (tlp_valid && tlp_last) begin
            m_body = 1'b0;
            m_syms.push_back({1'b1, tlp_nullify ? 8'hFE : 8'hFD});
          end
        end else begin
          m_syms.delete(0);
          if (m_pre) begin
            m_pre  = 1'b0;
            m_body = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    byte unsigned order[$];
    string        exp_s;
    int           k;
    int           nend;

    // Reset with a DLLP already pending: nothing may be granted in reset.
    rst_n = 1'b0;
    dllp_src.push_back(48'h0011_2233_4455);
    drive_inputs();
    step();
    mon_en = 1'b1;
    step();
    chk("rst_sym_valid",  sym_valid,  1'b0);
    chk("rst_sym_data",   sym_data,   8'h00);
    chk("rst_sym_dk",     sym_dk,     1'b0);
    chk("rst_tlp_ready",  tlp_ready,  1'b0);
    chk("rst_dllp_ready", dllp_ready, 1'b0);
    chk("rst_busy",       busy,       1'b0);

    // DLLP framing on 8 consecutive cycles, granted the cycle reset lifts.
    clear_log();
    dr_cnt = 0;
    rst_n  = 1'b1;
    wait_log(8, "dllp");
    repeat (3) step();
    exp_dllp(48'h0011_2233_4455);
    check_log("dllp");
    chk("dllp_consecutive", 64'(log_cyc[7] - log_cyc[0]), 64'd7);
    chk("dllp_ready_pulses", 64'(dr_cnt), 64'd1);
    chk("dllp_latency", 64'(log_cyc[0]), 64'(dr_cyc + 1));

    // Two TLPs back to back, the second nullified.
    clear_log();
    push_tlp(8'hA0, 4, 1'b0, 1'b0);
    push_tlp(8'hB0, 3, 1'b1, 1'b0);
    drive_inputs();
    wait_log(11, "tlp2");
    repeat (3) step();
    exp_tlp(8'hA0, 4, 1'b0);
    exp_tlp(8'hB0, 3, 1'b1);
    check_log("tlp2");
    chk("tlp2_no_gap", 64'(log_cyc[10] - log_cyc[0]), 64'd10);

    // Both sources saturated: DLLP burst limit sets the grant order.
    clear_log();
    push_tlp(8'h10, 2, 1'b0, 1'b0);
    push_tlp(8'h20, 2, 1'b0, 1'b0);
    push_tlp(8'h30, 2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) dllp_src.push_back(48'h1000_0000_0000 + 48'(i));
    drive_inputs();
    k = 0;
    while ((tlp_q.size() > 0 || dllp_src.size() > 0 || busy) && k < 300) begin
      step();
      k++;
    end
    chk("burst_drain_timeout", 64'(k < 300), 64'd1);
    for (int i = 0; i < log_sym.size(); i++) begin
      if (log_sym[i] == {1'b1, 8'hFB}) order.push_back(8'h54);
      if (log_sym[i] == {1'b1, 8'h5C}) order.push_back(8'h44);
    end
    exp_s = "DDTDDT";
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("grant_order%0d", i),
          (i < order.size()) ? 64'(order[i]) : 64'h0, 64'(exp_s[i]));
    end

    // Three stalled cycles in the middle of a TLP.
    clear_log();
    push_tlp(8'hC0, 6, 1'b0, 1'b0);
    drive_inputs();
    wait_log(3, "stall_pre");
    rdy_val = 1'b0;
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_sym_valid", sym_valid, 1'b1);
      chk("stall_sym_data",  sym_data,  8'hC2);
      chk("stall_tlp_ready", tlp_ready, 1'b0);
      step();
    end
    rdy_val = 1'b1;
    drive_inputs();
    wait_log(8, "stall");
    repeat (3) step();
    exp_tlp(8'hC0, 6, 1'b0);
    check_log("stall");

    // DLLP raised during a TLP payload waits for the TLP's END.
    clear_log();
    push_tlp(8'h40, 4, 1'b0, 1'b0);
    drive_inputs();
    wait_log(2, "nopreempt_pre");
    dllp_src.push_back(48'hAABB_CCDD_EEFF);
    drive_inputs();
    wait_log(14, "nopreempt");
    repeat (3) step();
    exp_tlp(8'h40, 4, 1'b0);
    exp_dllp(48'hAABB_CCDD_EEFF);
    check_log("nopreempt");
    chk("nopreempt_grant_at_end", 64'(dr_cyc), 64'(log_cyc[5]));
    chk("nopreempt_no_bubble", 64'(log_cyc[6] - log_cyc[5]), 64'd1);

    // Reset at DLLP byte 3, then a fresh DLLP starts from SDP.
    clear_log();
    dllp_src.push_back(48'h0011_2233_4455);
    drive_inputs();
    k = 0;
    while (!(sym_valid && !sym_dk && sym_data == 8'h33) && k < 50) begin
      step();
      k++;
    end
    chk("rst_mid_reach_byte3", sym_data, 8'h33);
    rst_n = 1'b0;
    step();
    chk("rst_mid_sym_valid", sym_valid, 1'b0);
    chk("rst_mid_busy",      busy,      1'b0);
    nend = 0;
    for (int i = 0; i < log_sym.size(); i++) if (log_sym[i][8]) nend += (log_sym[i][7:0] != 8'h5C);
    chk("rst_mid_no_close", 64'(nend), 64'd0);
    clear_log();
    dllp_src.push_back(48'h0123_4567_89AB);
    rst_n = 1'b1;
    drive_inputs();
    wait_log(8, "restart");
    repeat (3) step();
    exp_dllp(48'h0123_4567_89AB);
    check_log("restart");

    // Randomized traffic with source gaps and random backpressure.
    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (tlp_q.size() < 24 && $urandom_range(0, 7) == 0)
        push_tlp(8'h00, $urandom_range(1, 8), 1'($urandom), 1'b1);
      if (dllp_src.size() < 4 && $urandom_range(0, 9) == 0)
        dllp_src.push_back({16'($urandom), 32'($urandom)});
      if (c == 1500) rdy_rand = 1'b0;
      step();
    end
    gap_en   = 1'b0;
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    k = 0;
    while ((tlp_q.size() > 0 || dllp_src.size() > 0 || busy) && k < 3000) begin
      step();
      k++;
    end
    chk("random_drain_timeout", 64'(k < 3000), 64'd1);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen1_2_tx_scheduler.md
GEN1_2_TX_SCHEDULER -- requirements
Module: gen1_2_tx_scheduler

Interface
REQ-001 Parameter DLLP_BURST, default 2: maximum consecutive DLLP grants while a TLP is waiting.
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 Port tlp_valid, input, 1: TLP byte available on tlp_data.
REQ-005 Port tlp_data, input, 8: TLP byte stream, header first.
REQ-006 Port tlp_last, input, 1: current tlp_data byte is the final TLP byte.
REQ-007 Port tlp_nullify, input, 1: sampled with the tlp_last byte; the TLP is closed with EDB instead of END.
REQ-008 Port tlp_ready, output, 1: the TLP byte is consumed this cycle.
REQ-009 Port dllp_valid, input, 1: DLLP pending on dllp_data.
REQ-010 Port dllp_data, input, 48: 6-byte DLLP; byte 0 = [47:40], byte 5 = [7:0].
REQ-011 Port dllp_ready, output, 1: one-cycle pulse; dllp_data captured this cycle.
REQ-012 Port sym_data, output, 8: symbol to the Gen1/2 lane datapath.
REQ-013 Port sym_dk, output, 1: 1 = sym_data is a K-symbol, 0 = D-symbol.
REQ-014 Port sym_valid, output, 1: a symbol is presented this cycle.
REQ-015 Port sym_ready, input, 1: the datapath accepts the symbol; transfer = sym_valid & sym_ready.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 The block shall use seven states: IDLE, TLP_STP, TLP_BODY, TLP_END, DLLP_SDP, DLLP_BODY and DLLP_END.
REQ-018 Framing symbols with sym_dk=1 shall be: STP=0xFB, SDP=0x5C, END=0xFD, EDB=0xFE; all body bytes shall have sym_dk=0.
REQ-019 IDLE: sym_valid=0, sym_data=0x00, sym_dk=0.
REQ-020 Arbitration shall occur in IDLE and on the transfer cycle of TLP_END or DLLP_END, allowing back-to-back packets with no bubble.
REQ-021 Arbitration shall grant the DLLP if dllp_valid and (!tlp_valid or streak<DLLP_BURST); else grant the TLP if tlp_valid; else go to IDLE.
REQ-022 streak (counter 0..DLLP_BURST) shall increment on a DLLP grant while tlp_valid=1, and clear on a TLP grant or on a DLLP grant while tlp_valid=0.
REQ-023 DLLP grant: dllp_ready shall pulse for exactly the grant cycle, dllp_data shall be latched, the byte counter shall be cleared, and the next state shall be DLLP_SDP.
REQ-024 TLP grant: next state shall be TLP_STP; tlp_ready shall not assert on the grant cycle.
REQ-025 TLP_STP / DLLP_SDP / TLP_END / DLLP_END shall present sym_valid=1 and hold until the transfer.
REQ-026 TLP_BODY: sym_data=tlp_data, sym_valid=tlp_valid, tlp_ready=tlp_valid&sym_ready.
REQ-027 TLP_BODY: a tlp_valid gap shall produce sym_valid=0 with the state held (stall, no symbol inserted).
REQ-028 On the TLP_BODY transfer with tlp_last=1, tlp_nullify shall be latched and the state shall go to TLP_END.
REQ-029 TLP_END shall emit EDB if the latched nullify=1, else END.
REQ-030 DLLP_BODY shall emit latched bytes 0..5 in order, one per transfer; after byte 5 the state shall go to DLLP_END.
REQ-031 sym_ready=0 shall freeze state, counters and outputs; tlp_ready shall be 0 and no byte shall be consumed.
REQ-032 tlp_ready shall be 0 outside TLP_BODY; a TLP in flight shall never be preempted by a DLLP.
REQ-033 Latency: a request arriving in IDLE shall yield the framing symbol on sym_* in the next cycle.
REQ-034 Minimum framed sizes: DLLP = 8 symbols; TLP = payload bytes + 2 symbols.

Reset
REQ-035 With rst_n=0 at a clock edge, the block shall enter IDLE with sym_valid=0, sym_data=0x00, sym_dk=0, tlp_ready=0, dllp_ready=0, busy=0, streak=0, byte counter=0, nullify latch=0.
REQ-036 Reset mid-packet shall abandon the packet without emitting END/EDB; output resumes only on a new grant.

Verification
REQ-037 A bench shall cover: DLLP 0x0011_2233_4455, sym_ready=1 -> 5C(K),00,11,22,33,44,55,FD(K) on 8 consecutive cycles; dllp_ready pulses once.
REQ-038 A bench shall cover: 4-byte TLP A0..A3 with nullify=0, then a second TLP with nullify=1 queued -> FB,A0..A3,FD then FB,...,FE with no idle gap.
REQ-039 A bench shall cover: tlp_valid and dllp_valid held high continuously, DLLP_BURST=2 -> grant order D,D,T,D,D,T.
REQ-040 A bench shall cover: sym_ready low for 3 cycles mid-TLP -> sym_data held, tlp_ready=0, no byte lost or duplicated.
REQ-041 A bench shall cover: dllp_valid asserted during TLP_BODY -> the DLLP starts only after the TLP END transfer.
REQ-042 A bench shall cover: rst_n low at DLLP byte 3 -> next cycle sym_valid=0, busy=0; a new DLLP restarts from SDP.
